// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage datapath and the hazard unit.
// The datapath drives register indices and stage status; the unit returns forward selects and pipeline controls.
interface hazard_ctrl_if #(
  parameter int REG_WIDTH = 5,
  parameter int CNT_WIDTH = 16
);
  logic [REG_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                 regwriteE, regwriteM, regwriteW;
  logic                 loadE, loadM, dmem_ready, pcsrcE;
  logic [1:0]           forwardAE, forwardBE;
  logic                 stallF, stallD, stallE, stallM;
  logic                 flushD, flushE, flushW;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output regwriteE, regwriteM, regwriteW, loadE, loadM, dmem_ready, pcsrcE,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW, stall_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  regwriteE, regwriteM, regwriteW, loadE, loadM, dmem_ready, pcsrcE,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX forwarding, load-use or interlock bubbles, data-memory wait
// stalls, branch flushes and a saturating stall-cycle counter. Outputs are combinational.
module hazard_ctrl #(
  parameter int REG_WIDTH = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FWD_EN    = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {IDLE, LSTALL, MWAIT} state_t;

  localparam logic [REG_WIDTH-1:0] X0        = '0;
  localparam logic [2:0]           LAT_M1    = 3'(LOAD_LAT - 1);
  localparam bit                   LONG_LOAD = (FWD_EN != 0) && (LOAD_LAT > 1);

  // x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic hit(input logic [REG_WIDTH-1:0] rd, input logic en,
                               input logic [REG_WIDTH-1:0] rs);
    return en && (rd != X0) && (rd == rs);
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [1:0]           fwd_a, fwd_b;
  logic                 lwhaz, rawhaz, haz, memwait;
  logic                 stall_fd, stall_em, flush_d, flush_e, flush_w;

  assign lwhaz   = hit(hz.RdE, hz.loadE, hz.Rs1D) || hit(hz.RdE, hz.loadE, hz.Rs2D);
  assign rawhaz  = hit(hz.RdE, hz.regwriteE, hz.Rs1D) || hit(hz.RdE, hz.regwriteE, hz.Rs2D) ||
                   hit(hz.RdM, hz.regwriteM, hz.Rs1D) || hit(hz.RdM, hz.regwriteM, hz.Rs2D) ||
                   hit(hz.RdW, hz.regwriteW, hz.Rs1D) || hit(hz.RdW, hz.regwriteW, hz.Rs2D);
  assign haz     = (FWD_EN != 0) ? lwhaz : rawhaz;
  assign memwait = hz.loadM && !hz.dmem_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (hit(hz.RdM, hz.regwriteM, hz.Rs1E))      fwd_a = 2'b10;
      else if (hit(hz.RdW, hz.regwriteW, hz.Rs1E)) fwd_a = 2'b01;
      if (hit(hz.RdM, hz.regwriteM, hz.Rs2E))      fwd_b = 2'b10;
      else if (hit(hz.RdW, hz.regwriteW, hz.Rs2E)) fwd_b = 2'b01;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_fd = 1'b0;
    stall_em = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memwait) begin
          {stall_fd, stall_em, flush_w} = 3'b111;
          state_d = MWAIT;
        end else if (pcsrcE_taken()) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (haz) begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
          if (LONG_LOAD) begin
            state_d = LSTALL;
            cnt_d   = LAT_M1;
          end
        end
      end
      LSTALL: begin
        // A memory wait freezes the bubble sequence; cnt_q resumes after MWAIT.
        if (memwait) begin
          {stall_fd, stall_em, flush_w} = 3'b111;
          state_d = MWAIT;
        end else begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
          cnt_d    = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = IDLE;
        end
      end
      MWAIT: begin
        if (!hz.dmem_ready) begin
          {stall_fd, stall_em, flush_w} = 3'b111;
        end else begin
          state_d = (cnt_q != 3'd0) ? LSTALL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic pcsrcE_taken();
    return hz.pcsrcE;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_fd && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign hz.forwardAE = rst_n ? fwd_a : 2'b00;
  assign hz.forwardBE = rst_n ? fwd_b : 2'b00;
  assign hz.stallF    = rst_n & stall_fd;
  assign hz.stallD    = rst_n & stall_fd;
  assign hz.stallE    = rst_n & stall_em;
  assign hz.stallM    = rst_n & stall_em;
  assign hz.flushD    = rst_n & flush_d;
  assign hz.flushE    = rst_n & flush_e;
  assign hz.flushW    = rst_n & flush_w;
  assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised successor to the RV32I pipeline hazard unit. It covers:
- EX-stage operand forwarding.
- Load-use stalls of configurable length, for multi-cycle data memory.
- Data-memory wait stalls.
- Branch/jump flushes.
- Optional no-forwarding interlock mode.
- A saturating stall-cycle performance counter.

It sits beside the 5-stage datapath (F/D/E/M/W) and drives the pipeline-register enables and clears.

Parameters:
REG_WIDTH, 5, register-index width.
LOAD_LAT, 1, load-use bubbles inserted (1..7); 1 = classic single bubble.
FWD_EN, 1, 1 = forwarding enabled; 0 = interlock on every RAW hazard, forward outputs tied to 00.
CNT_WIDTH, 16, width of stall performance counter.

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
Rs1D  in  REG_WIDTH  rs1 index in decode.
Rs2D  in  REG_WIDTH  rs2 index in decode.
Rs1E  in  REG_WIDTH  rs1 index in execute.
Rs2E  in  REG_WIDTH  rs2 index in execute.
RdE  in  REG_WIDTH  destination index in execute.
RdM  in  REG_WIDTH  destination index in memory.
RdW  in  REG_WIDTH  destination index in writeback.
regwriteE  in  1  execute instruction writes a register.
regwriteM  in  1  memory instruction writes a register.
regwriteW  in  1  writeback instruction writes a register.
loadE  in  1  execute instruction is I_TYPE_LOAD.
loadM  in  1  memory instruction is a load or store.
dmem_ready  in  1  data memory completes access this cycle.
pcsrcE  in  1  taken branch/jump resolved in execute.
forwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM.
forwardBE  out  2  SrcB select, same encoding.
stallF  out  1  hold PC.
stallD  out  1  hold IF/ID.
stallE  out  1  hold ID/EX.
stallM  out  1  hold EX/MEM.
flushD  out  1  clear IF/ID.
flushE  out  1  clear ID/EX.
flushW  out  1  clear MEM/WB.
stall_cnt  out  CNT_WIDTH  cycles with stallF=1 since reset, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE, bubble counter to 0, stall_cnt to 0.
  - While rst_n=0, every stall/flush output is 0 and forwardAE/BE are 00.
- Register x0 is never a hazard: any compare with index 0 yields no match.

Forwarding (FWD_EN=1, combinational):
- forwardAE = 10 if regwriteM && RdM!=0 && RdM==Rs1E.
- Else forwardAE = 01 if regwriteW && RdW!=0 && RdW==Rs1E.
- Else forwardAE = 00.
- M wins over W. forwardBE uses Rs2E with identical rules.

Hazard terms:
- lwhaz = loadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FWD_EN=0: rawhaz = match of Rs1D or Rs2D against any of (RdE, regwriteE), (RdM, regwriteM), (RdW, regwriteW), excluding 0. rawhaz replaces lwhaz.
- memwait = loadM && !dmem_ready.

FSM states: IDLE, LSTALL, MWAIT.
- IDLE:
  - memwait → stallF/D/E/M=1, flushW=1; next MWAIT.
  - else pcsrcE → flushD=1, flushE=1, no stall; any coincident lwhaz is discarded (wrong path); stay IDLE.
  - else lwhaz → stallF=stallD=1, flushE=1. If LOAD_LAT>1: next LSTALL, cnt=LOAD_LAT-1. Else stay IDLE.
  - FWD_EN=0: rawhaz → same outputs, stay IDLE; re-evaluated every cycle until the writer retires.
- LSTALL:
  - stallF=stallD=1, flushE=1 every cycle; cnt decrements.
  - Returns to IDLE on the cycle cnt==1 is consumed.
  - memwait in LSTALL has priority: go to MWAIT, remaining cnt retained.
  - On MWAIT exit: back to LSTALL if cnt>0, else IDLE.
- MWAIT:
  - stallF/D/E/M=1, flushW=1 while !dmem_ready.
  - The cycle dmem_ready=1: all stalls drop that cycle and the state leaves MWAIT.
  - pcsrcE is ignored in MWAIT; E is frozen and the signal is re-evaluated after exit.
- Latency: all outputs are combinational from inputs plus state; no added cycle of latency.
- stall_cnt increments on each rising edge where stallF=1 and stays at all-ones once saturated.

Test Plan:
- Forward priority: regwriteM=1, RdM=5; regwriteW=1, RdW=5; Rs1E=5, Rs2E=0 → forwardAE=10, forwardBE=00. Set RdM=0 → forwardAE=01.
- Load-use, LOAD_LAT=1: loadE=1, RdE=2, Rs1D=2, Rs2D=3 → stallF=stallD=flushE=1 for exactly 1 cycle. Same inputs with loadE=0 → all 0. Rs1D=Rs2D=RdE=0 → no stall.
- Load-use, LOAD_LAT=3: same hazard → 3 consecutive cycles of stallD=flushE=1, then IDLE; stall_cnt=3.
- Memory wait: loadM=1, dmem_ready=0 for 4 cycles, then 1 → stallM=flushW=1 for 4 cycles, 0 on the 5th. Injected mid-LSTALL (LOAD_LAT=3) → MWAIT, then the remaining LSTALL cycles complete.
- Branch vs stall: pcsrcE=1 with lwhaz=1 → flushD=flushE=1, stallF=0, state stays IDLE. rst_n pulsed low mid-LSTALL → all outputs 0 immediately, stall_cnt=0.
- FWD_EN=0: regwriteM=1, RdM=7, Rs1D=7 → stallD=1 held until RdM/RdW no longer match; forwardAE/BE stay 00 throughout.
